// File: rtl/pc_unit_pkg.sv
// Shared types and defaults for the program-counter unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pc_unit_pkg;

    // Control state of the PC unit: fetching, or parked after a HALT.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pc_state_t;

    // Default geometry and vectors. Word-addressed memory by default.
    localparam int PC_W_DEF      = 32;
    localparam int INC_DEF       = 1;
    localparam int RESET_VEC_DEF = 0;
    localparam int IRQ_VEC_DEF   = 16;

endpackage

// File: rtl/pc_next_sel.sv
// Candidate next-PC mux: jump target, else branch target, else pc+INC.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the candidate is taken.
module pc_next_sel
    import pc_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int INC  = INC_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] seq,
    output logic [PC_W-1:0] nx
);

    // Increment sized to the PC so the add wraps silently modulo 2^PC_W.
    localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

    assign seq = pc + INC_V;

    // Jump outranks a simultaneously resolved branch.
    always_comb begin
        nx = seq;
        if (jump) begin
            nx = jump_target;
        end else if (branch_taken) begin
            nx = branch_target;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with halt/resume, stall and single-level interrupt entry/return.
// Latency: every redirect shows on pc_out one falling edge later; pc_next_seq is combinational.
// Backpressure: stall holds the PC in RUN, but a pending interrupt still enters (EPC = held PC).
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int INC       = INC_DEF,
    parameter int RESET_VEC = RESET_VEC_DEF,
    parameter int IRQ_VEC   = IRQ_VEC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            irq,
    input  logic            iret,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_next_seq,
    output logic [PC_W-1:0] epc,
    output logic            halted,
    output logic            in_isr,
    output logic            irq_ack
);

    localparam logic [PC_W-1:0] RESET_PC = PC_W'(RESET_VEC);
    localparam logic [PC_W-1:0] IRQ_PC   = PC_W'(IRQ_VEC);

    pc_state_t       state;
    pc_state_t       state_nx;
    logic [PC_W-1:0] pc_nx;
    logic [PC_W-1:0] epc_nx;
    logic            in_isr_nx;
    logic            irq_ack_nx;
    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] nx;

    pc_next_sel #(
        .PC_W (PC_W),
        .INC  (INC)
    ) u_next_sel (
        .pc            (pc_out),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .seq           (seq),
        .nx            (nx)
    );

    assign pc_next_seq = seq;
    assign halted      = (state == ST_HALTED);

    // Interrupts are only accepted when no handler is already running.
    logic irq_take;
    assign irq_take = irq && !in_isr;

    // Next-state and next-register selection for both control states.
    always_comb begin
        state_nx   = state;
        pc_nx      = pc_out;
        epc_nx     = epc;
        in_isr_nx  = in_isr;
        irq_ack_nx = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt_req) begin
                    // HALT wins over everything else; the PC parks on the HALT.
                    state_nx = ST_HALTED;
                end else if (irq_take) begin
                    // A stalled instruction has not completed, so it must re-execute.
                    epc_nx     = stall ? pc_out : nx;
                    pc_nx      = IRQ_PC;
                    in_isr_nx  = 1'b1;
                    irq_ack_nx = 1'b1;
                end else if (stall) begin
                    pc_nx = pc_out;
                end else if (iret && in_isr) begin
                    pc_nx     = epc;
                    in_isr_nx = 1'b0;
                end else begin
                    // A stray iret outside a handler is just a sequential step.
                    pc_nx = nx;
                end
            end
            ST_HALTED: begin
                if (irq_take) begin
                    // Wake-up entry returns past the HALT instruction.
                    epc_nx     = seq;
                    pc_nx      = IRQ_PC;
                    in_isr_nx  = 1'b1;
                    irq_ack_nx = 1'b1;
                    state_nx   = ST_RUN;
                end else if (resume) begin
                    pc_nx    = seq;
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase
    end

    // All architectural state advances on the falling edge; reset is synchronous.
    always_ff @(negedge clk) begin
        if (reset) begin
            state   <= ST_RUN;
            pc_out  <= RESET_PC;
            epc     <= '0;
            in_isr  <= 1'b0;
            irq_ack <= 1'b0;
        end else begin
            state   <= state_nx;
            pc_out  <= pc_nx;
            epc     <= epc_nx;
            in_isr  <= in_isr_nx;
            irq_ack <= irq_ack_nx;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a 32-bit word-addressed instance and an 8-bit byte-addressed
// instance share one stimulus stream; both are checked against a behavioural model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, halt_req, resume, branch_taken, jump, irq, iret;
    logic [31:0] branch_target, jump_target;

    logic [31:0] a_pc, a_seq, a_epc;
    logic        a_halted, a_isr, a_ack;
    logic [7:0]  b_pc, b_seq, b_epc;
    logic        b_halted, b_isr, b_ack;

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = 32-bit/INC 1, index 1 = 8-bit/INC 4.
    logic [31:0] m_pc  [2];
    logic [31:0] m_epc [2];
    logic        m_halt[2];
    logic        m_isr [2];
    logic        m_ack [2];

    always #5 clk = ~clk;

    pc_unit u_a (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .irq(irq), .iret(iret),
        .pc_out(a_pc), .pc_next_seq(a_seq), .epc(a_epc),
        .halted(a_halted), .in_isr(a_isr), .irq_ack(a_ack)
    );

    pc_unit #(.PC_W(8), .INC(4), .RESET_VEC(0), .IRQ_VEC(16)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
        .branch_taken(branch_taken), .branch_target(branch_target[7:0]),
        .jump(jump), .jump_target(jump_target[7:0]), .irq(irq), .iret(iret),
        .pc_out(b_pc), .pc_next_seq(b_seq), .epc(b_epc),
        .halted(b_halted), .in_isr(b_isr), .irq_ack(b_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural rules applied to one instance on a falling edge.
    task automatic model_edge(input int k);
        logic [31:0] mask, inc, seq, nx;
        mask = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        inc  = (k == 0) ? 32'd1 : 32'd4;
        seq  = (m_pc[k] + inc) & mask;
        if (jump)              nx = jump_target & mask;
        else if (branch_taken) nx = branch_target & mask;
        else                   nx = seq;
        m_ack[k] = 1'b0;
        if (reset) begin
            m_pc[k] = 0; m_epc[k] = 0; m_halt[k] = 1'b0; m_isr[k] = 1'b0;
        end else if (m_halt[k]) begin
            if (irq && !m_isr[k]) begin
                m_epc[k] = seq; m_pc[k] = 16; m_isr[k] = 1'b1; m_ack[k] = 1'b1; m_halt[k] = 1'b0;
            end else if (resume) begin
                m_pc[k] = seq; m_halt[k] = 1'b0;
            end
        end else if (halt_req) begin
            m_halt[k] = 1'b1;
        end else if (irq && !m_isr[k]) begin
            m_epc[k] = stall ? m_pc[k] : nx;
            m_pc[k] = 16; m_isr[k] = 1'b1; m_ack[k] = 1'b1;
        end else if (!stall) begin
            if (iret && m_isr[k]) begin
                m_pc[k] = m_epc[k]; m_isr[k] = 1'b0;
            end else begin
                m_pc[k] = nx;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ":a.pc"},     a_pc, m_pc[0]);
        chk({tag, ":a.seq"},    a_seq, m_pc[0] + 32'd1);
        chk({tag, ":a.epc"},    a_epc, m_epc[0]);
        chk({tag, ":a.halted"}, {31'd0, a_halted}, {31'd0, m_halt[0]});
        chk({tag, ":a.isr"},    {31'd0, a_isr}, {31'd0, m_isr[0]});
        chk({tag, ":a.ack"},    {31'd0, a_ack}, {31'd0, m_ack[0]});
        chk({tag, ":b.pc"},     {24'd0, b_pc}, m_pc[1]);
        chk({tag, ":b.seq"},    {24'd0, b_seq}, (m_pc[1] + 32'd4) & 32'hFF);
        chk({tag, ":b.epc"},    {24'd0, b_epc}, m_epc[1]);
        chk({tag, ":b.halted"}, {31'd0, b_halted}, {31'd0, m_halt[1]});
        chk({tag, ":b.isr"},    {31'd0, b_isr}, {31'd0, m_isr[1]});
        chk({tag, ":b.ack"},    {31'd0, b_ack}, {31'd0, m_ack[1]});
    endtask

    // Drive one cycle of inputs, advance one falling edge, then check.
    task automatic go(input string tag, input logic r, input logic st, input logic hr,
                      input logic rs, input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic iq, input logic ir);
        reset = r; stall = st; halt_req = hr; resume = rs;
        branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
        irq = iq; iret = ir;
        @(negedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
        branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
        irq = 1'b0; iret = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_epc[k] = 0; m_halt[k] = 0; m_isr[k] = 0; m_ack[k] = 0;
        end

        // Reset and sequential counting
        go("reset", 1, 0,0,0, 0,0, 0,0, 0,0);
        chk("reset_pc", a_pc, 32'd0);
        for (int i = 0; i < 4; i++) go("idle", 0, 0,0,0, 0,0, 0,0, 0,0);
        chk("count4", a_pc, 32'd4);
        go("reset_mid", 1, 0,0,0, 0,0, 0,0, 0,0);
        chk("reset_mid_pc", a_pc, 32'd0);
        for (int i = 0; i < 5; i++) go("idle", 0, 0,0,0, 0,0, 0,0, 0,0);

        // Jump beats branch, branch alone, stall holds
        go("jmp_br", 0, 0,0,0, 1,20, 1,40, 0,0);
        chk("jump_prio", a_pc, 32'd40);
        go("br", 0, 0,0,0, 1,20, 0,0, 0,0);
        chk("branch", a_pc, 32'd20);
        for (int i = 0; i < 3; i++) go("stall", 0, 1,0,0, 1,99, 1,77, 0,1);
        chk("stall_hold", a_pc, 32'd20);

        // Halt, hold, resume, halt beats resume in RUN
        go("to7", 0, 0,0,0, 0,0, 1,7, 0,0);
        go("halt", 0, 0,1,0, 0,0, 1,55, 0,0);
        chk("halt_pc", a_pc, 32'd7);
        for (int i = 0; i < 5; i++) go("halted", 0, 1,1,0, 1,3, 1,4, 0,1);
        go("resume", 0, 0,0,1, 0,0, 0,0, 0,0);
        chk("resume_pc", a_pc, 32'd8);
        go("halt_res", 0, 0,1,1, 0,0, 0,0, 0,0);
        chk("halt_wins", {31'd0, a_halted}, 32'd1);
        go("resume2", 0, 0,0,1, 0,0, 0,0, 0,0);

        // Interrupt entry with jump, masking, iret, re-entry
        go("to10", 0, 0,0,0, 0,0, 1,10, 0,0);
        go("irq_jmp", 0, 0,0,0, 0,0, 1,30, 1,0);
        chk("irq_epc", a_epc, 32'd30);
        chk("irq_pc", a_pc, 32'd16);
        go("irq_masked", 0, 0,0,0, 0,0, 0,0, 1,0);
        go("iret", 0, 0,0,0, 0,0, 0,0, 1,1);
        chk("iret_pc", a_pc, 32'd30);
        go("reentry", 0, 0,0,0, 0,0, 0,0, 1,0);
        chk("reentry_epc", a_epc, 32'd31);
        go("iret2", 0, 0,0,0, 0,0, 0,0, 0,1);

        // Stalled interrupt entry, wake from HALTED
        go("to12", 0, 0,0,0, 0,0, 1,12, 0,0);
        go("stall_irq", 0, 1,0,0, 0,0, 0,0, 1,0);
        chk("stall_irq_epc", a_epc, 32'd12);
        go("iret3", 0, 0,0,0, 0,0, 0,0, 0,1);
        go("to50", 0, 0,0,0, 0,0, 1,50, 0,0);
        go("halt50", 0, 0,1,0, 0,0, 0,0, 0,0);
        go("wake", 0, 0,0,1, 0,0, 0,0, 1,0);
        chk("wake_epc", a_epc, 32'd51);
        chk("wake_pc", a_pc, 32'd16);
        go("iret4", 0, 0,0,0, 0,0, 0,0, 0,1);

        // 8-bit wrap and stray iret
        go("to252", 0, 0,0,0, 0,0, 1,252, 0,0);
        go("wrap", 0, 0,0,0, 0,0, 0,0, 0,0);
        chk("wrap_b", {24'd0, b_pc}, 32'd0);
        go("stray_iret", 0, 0,0,0, 0,0, 0,0, 0,1);
        chk("stray_iret_b", {24'd0, b_pc}, 32'd4);

        // Reset inside an ISR and while halted
        go("isr_in", 0, 0,0,0, 0,0, 0,0, 1,0);
        go("reset_isr", 1, 0,0,0, 0,0, 0,0, 1,0);
        go("halt_r", 0, 0,1,0, 0,0, 0,0, 0,0);
        go("reset_halt", 1, 0,0,0, 0,0, 0,0, 0,0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            go("rand",
               ($urandom_range(0, 59) == 0),
               ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 14) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), $urandom,
               ($urandom_range(0, 5) == 0), $urandom,
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
